imm_gen_pipe: RTL and testbench

Registered, parametrised immediate/target generator for the decode stage of the 5-stage MIPS pipeline. It takes an instruction and its PC over a valid/ready handshake, classifies the immediate, and produces an XLEN-wide immediate plus a precomputed branch/jump target one cycle later. A skid buffer lets the decode/execute boundary stall and flush without losing or duplicating instructions.

---
 rtl/imm_pkg.sv | 34 +++
 rtl/imm_gen_pipe_if.sv | 40 ++++
 rtl/imm_decode.sv | 66 ++++++
 rtl/imm_gen_pipe.sv | 121 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
// imm_pkg: MIPS opcode/funct constants and immediate-class encodings shared by the immediate generator
package imm_pkg;

    localparam logic [5:0] RTYPE = 6'h00;
    localparam logic [5:0] J     = 6'h02;
    localparam logic [5:0] JAL   = 6'h03;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] BNE   = 6'h05;
    localparam logic [5:0] BLEZ  = 6'h06;
    localparam logic [5:0] BGTZ  = 6'h07;
    localparam logic [5:0] ANDI  = 6'h0C;
    localparam logic [5:0] ORI   = 6'h0D;
    localparam logic [5:0] XORI  = 6'h0E;
    localparam logic [5:0] LUI   = 6'h0F;

    localparam logic [5:0] SLL = 6'h00;
    localparam logic [5:0] SRL = 6'h02;
    localparam logic [5:0] SRA = 6'h03;

    typedef enum logic [2:0] {
        KIND_NONE   = 3'd0,
        KIND_SEXT   = 3'd1,
        KIND_ZEXT   = 3'd2,
        KIND_LUI    = 3'd3,
        KIND_SHAMT  = 3'd4,
        KIND_BRANCH = 3'd5,
        KIND_JUMP   = 3'd6
    } imm_kind_e;

    function automatic logic is_shift_imm(input logic [5:0] funct);
        return funct == SLL || funct == SRL || funct == SRA;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: valid/ready instruction input and immediate/target output bundle
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_kind;
    logic [XLEN-1:0] out_target;

    modport master (
        output in_valid,
        input  in_ready,
        output in_instr,
        output in_pc,
        input  out_valid,
        output out_ready,
        input  out_imm,
        input  out_kind,
        input  out_target
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_instr,
        input  in_pc,
        output out_valid,
        input  out_ready,
        output out_imm,
        output out_kind,
        output out_target
    );

endinterface

// File: rtl/imm_decode.sv
// imm_decode: combinational MIPS immediate classification, extension and branch/jump target
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      kind_o,
    output logic [XLEN-1:0] target_o
);

    logic [5:0]      op;
    logic [5:0]      funct;
    logic [XLEN-1:0] sext16;
    logic [XLEN-1:0] zext16;
    logic [XLEN-1:0] lui_imm;
    logic [XLEN-1:0] shamt;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] jmp_tgt;

    assign op      = instr_i[31:26];
    assign funct   = instr_i[5:0];
    assign sext16  = XLEN'($signed(instr_i[15:0]));
    assign zext16  = XLEN'(instr_i[15:0]);
    assign lui_imm = XLEN'($signed({instr_i[15:0], 16'h0000}));
    assign shamt   = XLEN'(instr_i[10:6]);
    assign pc4     = pc_i + XLEN'(4);
    assign br_off  = sext16 << 2;
    assign jmp_tgt = {pc4[XLEN-1:28], instr_i[25:0], 2'b00};

    // classify the opcode; unlisted opcodes fall through to sign-extended imm16
    always_comb begin
        kind_o   = KIND_SEXT;
        imm_o    = sext16;
        target_o = '0;
        case (op)
            ANDI, ORI, XORI: begin
                kind_o = KIND_ZEXT;
                imm_o  = zext16;
            end
            LUI: begin
                kind_o = KIND_LUI;
                imm_o  = lui_imm;
            end
            BEQ, BNE, BLEZ, BGTZ: begin
                kind_o   = KIND_BRANCH;
                imm_o    = br_off;
                target_o = pc4 + br_off;
            end
            J, JAL: begin
                kind_o   = KIND_JUMP;
                imm_o    = jmp_tgt;
                target_o = jmp_tgt;
            end
            RTYPE: begin
                kind_o = is_shift_imm(funct) ? KIND_SHAMT : KIND_NONE;
                imm_o  = is_shift_imm(funct) ? shamt : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate/target generator with optional skid buffer and flush
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_kind;
    logic [XLEN-1:0] dec_target;

    logic            out_valid_q;
    logic            out_valid_d;
    logic [XLEN-1:0] out_imm_q;
    logic [XLEN-1:0] out_imm_d;
    logic [2:0]      out_kind_q;
    logic [2:0]      out_kind_d;
    logic [XLEN-1:0] out_target_q;
    logic [XLEN-1:0] out_target_d;

    logic            skid_valid_q;
    logic            skid_valid_d;
    logic [XLEN-1:0] skid_imm_q;
    logic [XLEN-1:0] skid_imm_d;
    logic [2:0]      skid_kind_q;
    logic [2:0]      skid_kind_d;
    logic [XLEN-1:0] skid_target_q;
    logic [XLEN-1:0] skid_target_d;

    logic            in_ready_q;
    logic            in_ready;
    logic            in_fire;
    logic            out_free;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i  (bus.in_instr),
        .pc_i     (bus.in_pc),
        .imm_o    (dec_imm),
        .kind_o   (dec_kind),
        .target_o (dec_target)
    );

    // the skid variant only ever stalls on a full skid, so its ready comes straight from a flop
    assign in_ready = SKID_EN ? in_ready_q : (bus.out_ready || !out_valid_q);
    assign in_fire  = bus.in_valid && in_ready && !flush;
    assign out_free = !out_valid_q || bus.out_ready;

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_imm    = out_imm_q;
    assign bus.out_kind   = out_kind_q;
    assign bus.out_target = out_target_q;

    // refill the output from the skid first, else from the decoder; park new entries in the skid while stalled
    always_comb begin
        out_valid_d   = out_valid_q;
        out_imm_d     = out_imm_q;
        out_kind_d    = out_kind_q;
        out_target_d  = out_target_q;
        skid_valid_d  = skid_valid_q;
        skid_imm_d    = skid_imm_q;
        skid_kind_d   = skid_kind_q;
        skid_target_d = skid_target_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free && skid_valid_q) begin
            out_valid_d   = 1'b1;
            out_imm_d     = skid_imm_q;
            out_kind_d    = skid_kind_q;
            out_target_d  = skid_target_q;
            skid_valid_d  = in_fire;
            skid_imm_d    = in_fire ? dec_imm : skid_imm_q;
            skid_kind_d   = in_fire ? dec_kind : skid_kind_q;
            skid_target_d = in_fire ? dec_target : skid_target_q;
        end else if (out_free) begin
            out_valid_d  = in_fire;
            out_imm_d    = in_fire ? dec_imm : out_imm_q;
            out_kind_d   = in_fire ? dec_kind : out_kind_q;
            out_target_d = in_fire ? dec_target : out_target_q;
        end else if (in_fire) begin
            skid_valid_d  = 1'b1;
            skid_imm_d    = dec_imm;
            skid_kind_d   = dec_kind;
            skid_target_d = dec_target;
        end
        if (!SKID_EN) skid_valid_d = 1'b0;
    end

    // state registers; reset clears validity and zeroes the visible data
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_imm_q     <= '0;
            out_kind_q    <= KIND_NONE;
            out_target_q  <= '0;
            skid_valid_q  <= 1'b0;
            skid_imm_q    <= '0;
            skid_kind_q   <= KIND_NONE;
            skid_target_q <= '0;
            in_ready_q    <= 1'b1;
        end else begin
            out_valid_q   <= out_valid_d;
            out_imm_q     <= out_imm_d;
            out_kind_q    <= out_kind_d;
            out_target_q  <= out_target_d;
            skid_valid_q  <= skid_valid_d;
            skid_imm_q    <= skid_imm_d;
            skid_kind_q   <= skid_kind_d;
            skid_target_q <= skid_target_d;
            in_ready_q    <= !skid_valid_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and randomized check of three imm_gen_pipe configurations against a queue model
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  kind;
        logic [63:0] tgt;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [63:0] pc;

    int n_chk;
    int n_err;
    bit live;

    ent_t mq [3][$];
    int   xl [3] = '{32, 32, 64};
    bit   sk [3] = '{1'b1, 1'b0, 1'b1};

    logic        ov [3];
    logic        ir [3];
    logic [63:0] oi [3];
    logic [63:0] ot [3];
    logic [2:0]  ok [3];

    imm_gen_pipe_if #(.XLEN(32)) b0 ();
    imm_gen_pipe_if #(.XLEN(32)) b1 ();
    imm_gen_pipe_if #(.XLEN(64)) b2 ();

    imm_gen_pipe #(.XLEN(32), .SKID_EN(1'b1)) u0 (.clk(clk), .rst(rst), .flush(flush), .bus(b0));
    imm_gen_pipe #(.XLEN(32), .SKID_EN(1'b0)) u1 (.clk(clk), .rst(rst), .flush(flush), .bus(b1));
    imm_gen_pipe #(.XLEN(64), .SKID_EN(1'b1)) u2 (.clk(clk), .rst(rst), .flush(flush), .bus(b2));

    assign b0.in_valid  = in_valid;
    assign b0.in_instr  = instr;
    assign b0.in_pc     = pc[31:0];
    assign b0.out_ready = out_ready;
    assign b1.in_valid  = in_valid;
    assign b1.in_instr  = instr;
    assign b1.in_pc     = pc[31:0];
    assign b1.out_ready = out_ready;
    assign b2.in_valid  = in_valid;
    assign b2.in_instr  = instr;
    assign b2.in_pc     = pc;
    assign b2.out_ready = out_ready;

    assign ov[0] = b0.out_valid;
    assign ir[0] = b0.in_ready;
    assign oi[0] = {32'h0, b0.out_imm};
    assign ot[0] = {32'h0, b0.out_target};
    assign ok[0] = b0.out_kind;
    assign ov[1] = b1.out_valid;
    assign ir[1] = b1.in_ready;
    assign oi[1] = {32'h0, b1.out_imm};
    assign ot[1] = {32'h0, b1.out_target};
    assign ok[1] = b1.out_kind;
    assign ov[2] = b2.out_valid;
    assign ir[2] = b2.in_ready;
    assign oi[2] = b2.out_imm;
    assign ot[2] = b2.out_target;
    assign ok[2] = b2.out_kind;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ent_t ref_dec(input logic [31:0] ins, input logic [63:0] p, input int w);
        logic [63:0] m;
        logic [63:0] s;
        logic [63:0] pc4;
        logic [5:0]  op;
        ent_t        r;
        m   = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        s   = {{48{ins[15]}}, ins[15:0]};
        pc4 = (p + 64'd4) & m;
        op  = ins[31:26];
        r   = '0;
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) begin
            r.kind = 3'd2;
            r.imm  = {48'h0, ins[15:0]};
        end else if (op == 6'h0F) begin
            r.kind = 3'd3;
            r.imm  = {{32{ins[15]}}, ins[15:0], 16'h0} & m;
        end else if (op >= 6'h04 && op <= 6'h07) begin
            r.kind = 3'd5;
            r.imm  = (s * 64'd4) & m;
            r.tgt  = (pc4 + s * 64'd4) & m;
        end else if (op == 6'h02 || op == 6'h03) begin
            r.kind = 3'd6;
            r.imm  = (((pc4 >> 28) << 28) | {36'h0, ins[25:0], 2'b00}) & m;
            r.tgt  = r.imm;
        end else if (op == 6'h00) begin
            if (ins[5:0] == 6'h00 || ins[5:0] == 6'h02 || ins[5:0] == 6'h03) begin
                r.kind = 3'd4;
                r.imm  = {59'h0, ins[10:6]};
            end
        end else begin
            r.kind = 3'd1;
            r.imm  = s & m;
        end
        return r;
    endfunction

    function automatic bit exp_rdy(input int d);
        return sk[d] ? (mq[d].size() < 2) : (out_ready || mq[d].size() == 0);
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] p,
                         input logic ordy, input logic fl, input logic r);
        in_valid  = v;
        instr     = ins;
        pc        = p;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
    endtask

    task automatic tick();
        ent_t e;
        bit   rdy;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            if (live) begin
                check($sformatf("d%0d out_valid", d), 64'(ov[d]), 64'(mq[d].size() > 0));
                check($sformatf("d%0d in_ready", d), 64'(ir[d]), 64'(exp_rdy(d)));
                if (mq[d].size() > 0) begin
                    e = mq[d][0];
                    check($sformatf("d%0d out_imm", d), oi[d], e.imm);
                    check($sformatf("d%0d out_kind", d), 64'(ok[d]), 64'(e.kind));
                    check($sformatf("d%0d out_target", d), ot[d], e.tgt);
                end
            end
            rdy = exp_rdy(d);
            if (rst || flush) begin
                mq[d].delete();
            end else begin
                if (mq[d].size() > 0 && out_ready) void'(mq[d].pop_front());
                if (in_valid && rdy) mq[d].push_back(ref_dec(instr, pc, xl[d]));
            end
        end
        if (rst) live = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int d, input logic [63:0] imm,
                              input logic [2:0] k, input logic [63:0] t);
        check({tag, " valid"}, 64'(ov[d]), 64'd1);
        check({tag, " imm"}, oi[d], imm);
        check({tag, " kind"}, 64'(ok[d]), 64'(k));
        check({tag, " target"}, ot[d], t);
    endtask

    task automatic expect_reset();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst d%0d valid", d), 64'(ov[d]), 64'd0);
            check($sformatf("rst d%0d imm", d), oi[d], 64'd0);
            check($sformatf("rst d%0d kind", d), 64'(ok[d]), 64'd0);
            check($sformatf("rst d%0d target", d), ot[d], 64'd0);
            check($sformatf("rst d%0d in_ready", d), 64'(ir[d]), 64'd1);
        end
    endtask

    logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                             6'h07, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h08, 6'h23};
    logic [5:0] fns [5]  = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h2A};

    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        n_chk = 0;
        n_err = 0;
        live  = 1'b0;
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        expect_reset();
        drive(1'b1, 32'h2008FFFC, 64'h0040_0000, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("addi", 0, 64'hFFFF_FFFC, 3'd1, 64'h0);
        drive(1'b1, 32'h35088000, 64'h0040_0004, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("ori", 0, 64'h0000_8000, 3'd2, 64'h0);
        drive(1'b1, 32'h3C081234, 64'h0040_0008, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("lui", 0, 64'h1234_0000, 3'd3, 64'h0);
        drive(1'b1, 32'h00084080, 64'h0040_000C, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("sll", 0, 64'd2, 3'd4, 64'h0);
        drive(1'b1, 32'h3C088000, 64'h0040_0010, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("lui64", 2, 64'hFFFF_FFFF_8000_0000, 3'd3, 64'h0);
        expect_out("lui32", 0, 64'h8000_0000, 3'd3, 64'h0);
        drive(1'b1, 32'h1000FFFF, 64'h0040_0010, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("beq", 0, 64'hFFFF_FFFC, 3'd5, 64'h0040_0010);
        drive(1'b1, 32'h08100004, 64'h0040_0000, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("j", 0, 64'h0040_0010, 3'd6, 64'h0040_0010);
        drive(1'b1, 32'h00000020, 64'h0040_0020, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("add", 0, 64'h0, 3'd0, 64'h0);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        tick();
        check("drain valid", 64'(ov[0]), 64'd0);
        drive(1'b1, 32'h20000001, 64'h100, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("stall a", 0, 64'd1, 3'd1, 64'h0);
        drive(1'b1, 32'h20000002, 64'h104, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("stall a held", 0, 64'd1, 3'd1, 64'h0);
        check("skid full ready", 64'(ir[0]), 64'd0);
        check("noskid stalled ready", 64'(ir[1]), 64'd0);
        drive(1'b1, 32'h20000003, 64'h108, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("stall a held2", 0, 64'd1, 3'd1, 64'h0);
        drive(1'b1, 32'h20000003, 64'h108, 1'b1, 1'b0, 1'b0);
        #1;
        check("noskid comb ready", 64'(ir[1]), 64'd1);
        check("skid reg ready", 64'(ir[0]), 64'd0);
        tick();
        expect_out("drain b", 0, 64'd2, 3'd1, 64'h0);
        expect_out("noskid c", 1, 64'd3, 3'd1, 64'h0);
        tick();
        expect_out("drain c", 0, 64'd3, 3'd1, 64'h0);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        tick();
        check("no bubble", 64'(ov[0]), 64'd0);
        drive(1'b1, 32'h20000001, 64'h200, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h20000002, 64'h204, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h20000003, 64'h208, 1'b0, 1'b1, 1'b0);
        tick();
        check("flush valid", 64'(ov[0]), 64'd0);
        check("flush ready", 64'(ir[0]), 64'd1);
        check("flush noskid valid", 64'(ov[1]), 64'd0);
        drive(1'b1, 32'h20000004, 64'h20C, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("post flush", 0, 64'd4, 3'd1, 64'h0);
        drive(1'b1, 32'h20000001, 64'h300, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h20000002, 64'h304, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h20000003, 64'h308, 1'b0, 1'b1, 1'b1);
        tick();
        expect_reset();
        for (int i = 0; i < 800; i++) begin
            r   = $urandom();
            ins = {ops[$urandom_range(0, 13)], r[25:0]};
            if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 4)];
            if ($urandom_range(0, 15) == 0) ins = $urandom();
            drive($urandom_range(0, 9) < 7, ins, {$urandom(), $urandom()},
                  $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
            tick();
        end
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
